// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop line synchroniser, mid-bit sampling FSM,
// one-cycle Rx_Done / Frame_Error pulses and a held output byte.
module uart_rx #(
    parameter int clks_per_bit = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Rx_Serial,
    output logic [7:0] Rx_Parallel,
    output logic       Rx_Done,
    output logic       Frame_Error,
    output logic       Busy
);

    localparam logic [9:0] HALF = 10'((clks_per_bit - 1) / 2);
    localparam logic [9:0] LAST = 10'(clks_per_bit - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;

    logic [1:0] sync;
    logic       rx_s;
    logic [2:0] state;
    logic [9:0] cnt;
    logic [2:0] idx;
    logic [7:0] shreg;

    // Both stages reset high so a released reset never looks like a start edge
    // unless the line really is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync <= 2'b11;
        else       sync <= {sync[0], Rx_Serial};
    end

    assign rx_s = sync[1];
    assign Busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 10'd0;
            idx         <= 3'd0;
            shreg       <= 8'h00;
            Rx_Parallel <= 8'h00;
            Rx_Done     <= 1'b0;
            Frame_Error <= 1'b0;
        end else begin
            Rx_Done     <= 1'b0;
            Frame_Error <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= 10'd0;
                    idx <= 3'd0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    // A start bit must still be low half a bit in, else it was noise.
                    if (cnt == HALF) begin
                        cnt   <= 10'd0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
                        cnt        <= 10'd0;
                        shreg[idx] <= rx_s;
                        if (idx == 3'd7) begin
                            idx   <= 3'd0;
                            state <= STOP;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                STOP: begin
                    if (cnt == LAST) begin
                        cnt <= 10'd0;
                        if (rx_s) begin
                            Rx_Parallel <= shreg;
                            Rx_Done     <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            Frame_Error <= 1'b1;
                            state       <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                WAIT_HIGH: begin
                    // Hold off on a break so it yields one error and no bytes.
                    if (rx_s) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 10'd0;
                    idx   <= 3'd0;
                end
            endcase
        end
    end

endmodule
